// File: rtl/data_path_pkg.sv
// Shared types and constants for the generator-to-BRAM data path.
package data_path_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_WRITE   = 2'd3
  } wr_state_e;

  localparam logic [7:0] BRAM_WE_ALL = 8'hFF;

endpackage

// File: rtl/fifo_to_bram_writer.sv
// Drains the generator FIFO into a BRAM ring buffer one 64-bit word per four cycles,
// never overrunning the PS read index.
module fifo_to_bram_writer
  import data_path_pkg::*;
#(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic                  clear_pointers,
  input  logic [ADDR_WIDTH-1:0] ps_read_index,
  input  logic [ADDR_WIDTH-1:0] threshold,
  input  logic                  fifo_empty,
  input  logic [63:0]           fifo_read_data,
  output logic                  fifo_rd_en,
  output logic                  bram_en,
  output logic [7:0]            bram_we,
  output logic [ADDR_WIDTH+2:0] bram_addr,
  output logic [63:0]           bram_din,
  output logic [ADDR_WIDTH-1:0] write_index,
  output logic [31:0]           wrap_count,
  output logic [31:0]           words_written,
  output logic [ADDR_WIDTH-1:0] pending_words,
  output logic                  data_ready,
  output logic                  buffer_full_seen,
  output wr_state_e             dbg_state
);

  // One slot is always kept free so a full ring is distinguishable from an empty one.
  localparam logic [ADDR_WIDTH-1:0] FULL_LEVEL = '1;

  wr_state_e             state_q, state_d;
  logic [63:0]           data_q, data_d;
  logic [ADDR_WIDTH-1:0] wr_idx_q, wr_idx_d;
  logic [31:0]           wrap_q, wrap_d;
  logic [31:0]           words_q, words_d;
  logic                  full_seen_q, full_seen_d;
  logic                  clr_pend_q, clr_pend_d;

  logic ring_full;
  logic clr_req;
  logic start;

  assign pending_words = wr_idx_q - ps_read_index;
  assign data_ready    = (threshold != '0) && (pending_words >= threshold);
  assign ring_full     = (pending_words == FULL_LEVEL);
  // A clear seen while a word is in flight is remembered until the FSM is back in IDLE.
  assign clr_req       = clear_pointers | clr_pend_q;
  assign start         = enable & ~fifo_empty & ~clr_req & ~ring_full;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_FETCH;
      ST_FETCH:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_WRITE;
      ST_WRITE:   state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_en = (state_q == ST_FETCH);
    bram_en    = (state_q == ST_WRITE);
    bram_we    = (state_q == ST_WRITE) ? BRAM_WE_ALL : 8'h00;
    bram_din   = (state_q == ST_WRITE) ? data_q : 64'd0;
    bram_addr  = {wr_idx_q, 3'b000};
  end

  always_comb begin
    data_d      = data_q;
    wr_idx_d    = wr_idx_q;
    wrap_d      = wrap_q;
    words_d     = words_q;
    full_seen_d = full_seen_q;
    clr_pend_d  = clr_pend_q;
    case (state_q)
      ST_IDLE: begin
        clr_pend_d = 1'b0;
        if (clr_req) begin
          wr_idx_d    = '0;
          wrap_d      = 32'd0;
          words_d     = 32'd0;
          full_seen_d = 1'b0;
        end else if (enable && !fifo_empty && ring_full) begin
          full_seen_d = 1'b1;
        end
      end
      ST_CAPTURE: begin
        data_d = fifo_read_data;
        if (clear_pointers) clr_pend_d = 1'b1;
      end
      ST_WRITE: begin
        wr_idx_d = wr_idx_q + ADDR_WIDTH'(1);
        words_d  = words_q + 32'd1;
        if (wr_idx_q == FULL_LEVEL) wrap_d = wrap_q + 32'd1;
        if (clear_pointers) clr_pend_d = 1'b1;
      end
      default: begin
        if (clear_pointers) clr_pend_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_q      <= 64'd0;
      wr_idx_q    <= '0;
      wrap_q      <= 32'd0;
      words_q     <= 32'd0;
      full_seen_q <= 1'b0;
      clr_pend_q  <= 1'b0;
    end else begin
      data_q      <= data_d;
      wr_idx_q    <= wr_idx_d;
      wrap_q      <= wrap_d;
      words_q     <= words_d;
      full_seen_q <= full_seen_d;
      clr_pend_q  <= clr_pend_d;
    end
  end

  assign write_index      = wr_idx_q;
  assign wrap_count       = wrap_q;
  assign words_written    = words_q;
  assign buffer_full_seen = full_seen_q;
  assign dbg_state        = state_q;

endmodule
